// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// serial_pkg
// Shared defaults and width helpers for the serial port buffer.
// Rev 1.0
// ============================================================================
package serial_pkg;

  localparam int DATA_W_DEFAULT = 8;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo
// First-word-fall-through synchronous FIFO with occupancy count.
// Full/empty come from the registered count, so a push into a full FIFO is
// refused even when a pop happens on the same edge.
// Rev 1.0
// ============================================================================
module sync_fifo
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              wdata,
  output logic [WIDTH-1:0]              rdata,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array: write the accepted word at the tail; no reset needed.
  always_ff @(posedge clock) begin
    if (do_push && !reset) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally (power-of-two depth); count tracks accepted traffic.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_port_buffer.sv
`default_nettype none
// ============================================================================
// serial_port_buffer
// Bidirectional buffer between the processor serial port and external
// serial pins: TX FIFO drained by valid/ready, RX FIFO read by valid/rden,
// with occupancy counts and sticky overflow/underflow flags.
// Rev 1.0
// ============================================================================
module serial_port_buffer
  import serial_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             cpu_wren_in,
  input  logic [DATA_W-1:0]                cpu_data_in,
  output logic                             cpu_ready_out,
  input  logic                             cpu_rden_in,
  output logic [DATA_W-1:0]                cpu_data_out,
  output logic                             cpu_valid_out,
  output logic [DATA_W-1:0]                tx_data_out,
  output logic                             tx_valid_out,
  input  logic                             tx_ready_in,
  input  logic [DATA_W-1:0]                rx_data_in,
  input  logic                             rx_valid_in,
  output logic                             rx_ready_out,
  output logic [count_width(TX_DEPTH)-1:0] tx_count_out,
  output logic [count_width(RX_DEPTH)-1:0] rx_count_out,
  input  logic                             clear_flags_in,
  output logic                             tx_overflow_out,
  output logic                             rx_underflow_out
);

  logic tx_full;
  logic tx_empty;
  logic rx_full;
  logic rx_empty;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (cpu_wren_in),
    .pop   (tx_ready_in),
    .wdata (cpu_data_in),
    .rdata (tx_data_out),
    .count (tx_count_out),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_valid_in),
    .pop   (cpu_rden_in),
    .wdata (rx_data_in),
    .rdata (cpu_data_out),
    .count (rx_count_out),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign cpu_ready_out = !tx_full;
  assign tx_valid_out  = !tx_empty;
  assign rx_ready_out  = !rx_full;
  assign cpu_valid_out = !rx_empty;

  // Sticky error flags; a new error on the clearing edge keeps the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_overflow_out  <= 1'b0;
      rx_underflow_out <= 1'b0;
    end else begin
      if (cpu_wren_in && tx_full)     tx_overflow_out <= 1'b1;
      else if (clear_flags_in)        tx_overflow_out <= 1'b0;
      if (cpu_rden_in && rx_empty)    rx_underflow_out <= 1'b1;
      else if (clear_flags_in)        rx_underflow_out <= 1'b0;
    end
  end

endmodule
`default_nettype wire
